video_sync_timer: RTL and testbench
===================================

# video_sync_timer

Parametrised raster timing generator producing horizontal and vertical sync, pixel/line position, active-video flag and line/frame strobes from a single system clock. It replaces the separate per-axis sync counters in the display path with one block whose widths, pixel-clock ratio and sync polarities are configurable. Timing values are double-buffered so they change only on frame boundaries. It sits between the clock/reset logic and the pixel generator/VGA output stage.

## Interface
Parameters:
- XRES_W, 10, width of horizontal timing inputs and xposition
- YRES_W, 10, width of vertical timing inputs and yposition
- PIX_DIV, 2, CLK cycles per pixel (≥1)
- HSYNC_POL, 0, active level of hsync
- VSYNC_POL, 0, active level of vsync

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RESET  input  1  asynchronous, active-low reset
- enable  input  1  run timer; low clears counters
- h_active, h_front, h_sync, h_back  input  XRES_W each  horizontal segment lengths in pixels
- v_active, v_front, v_sync, v_back  input  YRES_W each  vertical segment lengths in lines
- pixel_tick  output  1  one-CLK strobe per pixel
- xposition  output  XRES_W  current pixel column
- yposition  output  YRES_W  current line
- hsync, vsync  output  1  sync pulses, polarity per parameter
- video_on  output  1  high when x < h_active and y < v_active
- line_end, frame_end  output  1  one-CLK strobes
- timing_err  output  1  illegal shadow timing (see Configuration)

## Operation
- Line order: Active, FrontPorch, Sync, BackPorch; same for frame.
- H_total = sum of h_* (computed XRES_W+2 bits); V_total likewise.
- Prescaler counts 0..PIX_DIV-1 while enable; pixel_tick high when it reaches PIX_DIV-1. PIX_DIV=1: pixel_tick = enable.
- On pixel_tick: x increments; at x = H_total-1 x wraps to 0, line_end pulses.
- On line_end: y increments; at y = V_total-1 y wraps to 0, frame_end pulses (coincident with line_end).
- hsync active iff h_active+h_front ≤ x ≤ h_active+h_front+h_sync-1 (exactly h_sync pixels); vsync same with v_* (exactly v_sync lines).
- Shadow registers: while enable=0, shadows track inputs every cycle; while enable=1, shadows load only in the frame_end cycle. All decode uses shadows, never live inputs.
- enable falling: next cycle prescaler, x, y cleared, strobes low, syncs inactive. enable rising: counting starts from x=0,y=0, first pixel_tick PIX_DIV cycles later.
- Reset values: x=0, y=0, prescaler=0, shadows=0, pixel_tick/line_end/frame_end/video_on/timing_err=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
- Reset mid-frame: immediate return to reset values, asynchronously.

## Timing
- hsync, vsync, video_on registered and aligned with xposition/yposition in the same cycle (no skew).
- line_end/frame_end asserted in the same cycle as the pixel_tick that wraps x; xposition shows 0 the following cycle.
- Line period = H_total·PIX_DIV CLK; frame period = H_total·V_total·PIX_DIV CLK.
- New timing inputs take effect on the first pixel of the next frame.

## Configuration
- VIDEO_TIMING_CHECK_EN defined: timing_err=1 while shadow h_active, h_sync, v_active or v_sync is 0, or H_total > 2^XRES_W, or V_total > 2^YRES_W; while set, x/y held at 0, syncs inactive, video_on=0, strobes low; re-evaluated each shadow load.
- Not defined: timing_err tied 0; totals truncated to axis width, wrap modulo 2^width; illegal values give unspecified but non-hanging sequencing.

## Structure
- Package video_timing_pkg: sync polarity constants, default 640x480 timing constants, total-width helper function.
- Sub-module sync_axis_counter (width parameter): counter, wrap, sync-window and active decode for one axis; instantiated twice (H advanced by pixel_tick, V by line_end).

## Test plan
Bench setup: PIX_DIV=2, h=4/1/2/1 (H_total 8), v=3/1/1/1 (V_total 6), polarities 0.
- RESET low then released, enable=0 -> all outputs at reset values, hsync=vsync=1.
- enable=1 -> pixel_tick every 2 CLK; hsync=0 for x=5,6 only; line_end every 16 CLK; video_on for x 0..3, y 0..2.
- Run 2 frames -> frame_end every 96 CLK coincident with line_end; vsync=0 only for y=4.
- Change h_active to 6 at y=1 -> current frame keeps H_total 8; after frame_end line period becomes 20 CLK.
- enable low at x=3,y=2 -> next cycle x=y=0, strobes stop; re-enable restarts from 0.
- VIDEO_TIMING_CHECK_EN, h_sync=0 while enable=0 -> timing_err=1, hsync inactive, x held 0; restore h_sync=2 -> timing_err=0.

Source files
------------

// File: rtl/video_sync_timer_pkg.sv
// Shared constants for the raster timing generator: sync polarities,
// default 640x480 timing and the width helper for segment-sum totals.
package video_timing_pkg;

   localparam logic SYNC_ACTIVE_LOW  = 1'b0;
   localparam logic SYNC_ACTIVE_HIGH = 1'b1;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FRONT  = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BACK   = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FRONT  = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BACK   = 33;

   // Sum of four w-bit segment lengths needs two extra bits.
   function automatic int unsigned total_width(input int unsigned w);
      return w + 2;
   endfunction

endpackage

// File: rtl/video_sync_timer_axis.sv
// One raster axis: position counter with wrap, plus registered sync-window
// and active-region flags decoded from the next count so they align with it.
module sync_axis_counter
   import video_timing_pkg::*;
#(
   parameter int unsigned W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         adv,
   input  logic [W+1:0] total,
   input  logic [W-1:0] act_len,
   input  logic [W-1:0] front_len,
   input  logic [W-1:0] sync_len,
   output logic [W-1:0] cnt,
   output logic         last,
   output logic         in_sync,
   output logic         in_act
);

   localparam int unsigned TW = total_width(W);

   logic [W-1:0]  nxt;
   logic [TW-1:0] nxt_w;
   logic [TW-1:0] total_m1;
   logic [TW-1:0] sync_start;
   logic [TW-1:0] sync_stop;

   // Truncation to W bits makes a zero or oversize total wrap at 2^W.
   assign total_m1 = total - TW'(1);
   assign last     = (cnt == total_m1[W-1:0]);

   always_comb begin
      nxt = cnt;
      if (adv) nxt = last ? '0 : cnt + W'(1);
      nxt_w      = TW'(nxt);
      sync_start = TW'(act_len) + TW'(front_len);
      sync_stop  = sync_start + TW'(sync_len);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         in_sync <= 1'b0;
         in_act  <= 1'b0;
      end else if (clr) begin
         cnt     <= '0;
         in_sync <= 1'b0;
         in_act  <= 1'b0;
      end else begin
         cnt     <= nxt;
         in_sync <= (nxt_w >= sync_start) && (nxt_w < sync_stop);
         in_act  <= (nxt < act_len);
      end
   end

endmodule

// File: rtl/video_sync_timer.sv
// Raster timing generator with frame-boundary double-buffered timing.
// Optional legality checking is enabled by defining VIDEO_TIMING_CHECK_EN.
module video_sync_timer
   import video_timing_pkg::*;
#(
   parameter int unsigned XRES_W    = 10,
   parameter int unsigned YRES_W    = 10,
   parameter int unsigned PIX_DIV   = 2,
   parameter logic        HSYNC_POL = SYNC_ACTIVE_LOW,
   parameter logic        VSYNC_POL = SYNC_ACTIVE_LOW
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              enable,
   input  logic [XRES_W-1:0] h_active,
   input  logic [XRES_W-1:0] h_front,
   input  logic [XRES_W-1:0] h_sync,
   input  logic [XRES_W-1:0] h_back,
   input  logic [YRES_W-1:0] v_active,
   input  logic [YRES_W-1:0] v_front,
   input  logic [YRES_W-1:0] v_sync,
   input  logic [YRES_W-1:0] v_back,
   output logic              pixel_tick,
   output logic [XRES_W-1:0] xposition,
   output logic [YRES_W-1:0] yposition,
   output logic              hsync,
   output logic              vsync,
   output logic              video_on,
   output logic              line_end,
   output logic              frame_end,
   output logic              timing_err
);

   localparam int unsigned HT_W = total_width(XRES_W);
   localparam int unsigned VT_W = total_width(YRES_W);
   localparam int unsigned PW   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(PIX_DIV - 1);

   logic [XRES_W-1:0] sh_ha, sh_hf, sh_hs, sh_hb, nx_ha, nx_hf, nx_hs, nx_hb;
   logic [YRES_W-1:0] sh_va, sh_vf, sh_vs, sh_vb, nx_va, nx_vf, nx_vs, nx_vb;
   logic [HT_W-1:0]   h_tot;
   logic [VT_W-1:0]   v_tot;
   logic [PW-1:0]     presc;
   logic              tick_r, err_r, err_n, run;
   logic              h_last, v_last, h_in_sync, v_in_sync, h_in_act, v_in_act;

   // Shadows follow the inputs while idle and otherwise reload only at frame end.
   always_comb begin
      nx_ha = sh_ha; nx_hf = sh_hf; nx_hs = sh_hs; nx_hb = sh_hb;
      nx_va = sh_va; nx_vf = sh_vf; nx_vs = sh_vs; nx_vb = sh_vb;
      if (!enable || frame_end) begin
         nx_ha = h_active; nx_hf = h_front; nx_hs = h_sync; nx_hb = h_back;
         nx_va = v_active; nx_vf = v_front; nx_vs = v_sync; nx_vb = v_back;
      end
   end

`ifdef VIDEO_TIMING_CHECK_EN
   localparam logic [HT_W-1:0] H_LIM = HT_W'(1) << XRES_W;
   localparam logic [VT_W-1:0] V_LIM = VT_W'(1) << YRES_W;
   logic [HT_W-1:0] nh_tot;
   logic [VT_W-1:0] nv_tot;
   assign nh_tot = HT_W'(nx_ha) + HT_W'(nx_hf) + HT_W'(nx_hs) + HT_W'(nx_hb);
   assign nv_tot = VT_W'(nx_va) + VT_W'(nx_vf) + VT_W'(nx_vs) + VT_W'(nx_vb);
   assign err_n  = (nx_ha == '0) || (nx_hs == '0) || (nx_va == '0) || (nx_vs == '0)
                || (nh_tot > H_LIM) || (nv_tot > V_LIM);
`else
   assign err_n = 1'b0;
`endif

   assign run   = enable && !err_n;
   assign h_tot = HT_W'(sh_ha) + HT_W'(sh_hf) + HT_W'(sh_hs) + HT_W'(sh_hb);
   assign v_tot = VT_W'(sh_va) + VT_W'(sh_vf) + VT_W'(sh_vs) + VT_W'(sh_vb);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sh_ha <= '0; sh_hf <= '0; sh_hs <= '0; sh_hb <= '0;
         sh_va <= '0; sh_vf <= '0; sh_vs <= '0; sh_vb <= '0;
         err_r <= 1'b0;
      end else begin
         sh_ha <= nx_ha; sh_hf <= nx_hf; sh_hs <= nx_hs; sh_hb <= nx_hb;
         sh_va <= nx_va; sh_vf <= nx_vf; sh_vs <= nx_vs; sh_vb <= nx_vb;
         err_r <= err_n;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         presc  <= '0;
         tick_r <= 1'b0;
      end else if (!run) begin
         presc  <= '0;
         tick_r <= 1'b0;
      end else begin
         presc  <= (presc == P_LAST) ? '0 : presc + PW'(1);
         tick_r <= (presc == P_LAST);
      end
   end

   // Decode uses the next shadow values so the first pixel of a frame sees new timing.
   sync_axis_counter #(.W(XRES_W)) u_h (
      .clk(CLK), .rst_n(RESET), .clr(!run), .adv(tick_r), .total(h_tot),
      .act_len(nx_ha), .front_len(nx_hf), .sync_len(nx_hs),
      .cnt(xposition), .last(h_last), .in_sync(h_in_sync), .in_act(h_in_act)
   );

   sync_axis_counter #(.W(YRES_W)) u_v (
      .clk(CLK), .rst_n(RESET), .clr(!run), .adv(line_end), .total(v_tot),
      .act_len(nx_va), .front_len(nx_vf), .sync_len(nx_vs),
      .cnt(yposition), .last(v_last), .in_sync(v_in_sync), .in_act(v_in_act)
   );

   assign pixel_tick = tick_r;
   assign line_end   = tick_r && h_last;
   assign frame_end  = line_end && v_last;
   assign video_on   = h_in_act && v_in_act;
   assign hsync      = h_in_sync ? HSYNC_POL : ~HSYNC_POL;
   assign vsync      = v_in_sync ? VSYNC_POL : ~VSYNC_POL;
   assign timing_err = err_r;

endmodule

// File: tb/tb_video_sync_timer.sv
// Directed bench for video_sync_timer: PIX_DIV=2, H 4/1/2/1, V 3/1/1/1.
module tb_video_sync_timer;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       enable = 1'b0;
   logic [9:0] h_active = 10'd4, h_front = 10'd1, h_sync = 10'd2, h_back = 10'd1;
   logic [9:0] v_active = 10'd3, v_front = 10'd1, v_sync = 10'd1, v_back = 10'd1;
   logic       pixel_tick, hsync, vsync, video_on, line_end, frame_end, timing_err;
   logic [9:0] xposition, yposition;

   int checks = 0;
   int errors = 0;
   int k = 0;

   always #5 CLK = ~CLK;

   video_sync_timer #(
      .XRES_W(10), .YRES_W(10), .PIX_DIV(2), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
   ) dut (
      .CLK(CLK), .RESET(RESET), .enable(enable),
      .h_active(h_active), .h_front(h_front), .h_sync(h_sync), .h_back(h_back),
      .v_active(v_active), .v_front(v_front), .v_sync(v_sync), .v_back(v_back),
      .pixel_tick(pixel_tick), .xposition(xposition), .yposition(yposition),
      .hsync(hsync), .vsync(vsync), .video_on(video_on),
      .line_end(line_end), .frame_end(frame_end), .timing_err(timing_err)
   );

   task automatic step();
      @(posedge CLK);
      #1;
      k++;
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      #12;
      checks++; if (xposition !== 10'd0) begin errors++; $display("FAIL reset_x got %0d want 0", xposition); end
      checks++; if (yposition !== 10'd0) begin errors++; $display("FAIL reset_y got %0d want 0", yposition); end
      checks++; if ({pixel_tick, line_end, frame_end, video_on, timing_err} !== 5'b0)
         begin errors++; $display("FAIL reset_flags got %b want 00000", {pixel_tick, line_end, frame_end, video_on, timing_err}); end
      checks++; if ({hsync, vsync} !== 2'b11) begin errors++; $display("FAIL reset_sync got %b want 11", {hsync, vsync}); end
      @(negedge CLK);
      RESET = 1'b1;
      for (int i = 0; i < 3; i++) step();
      checks++; if ({pixel_tick, xposition, video_on, hsync, vsync} !== {1'b0, 10'd0, 1'b0, 1'b1, 1'b1})
         begin errors++; $display("FAIL idle_outputs tick=%b x=%0d von=%b hs=%b vs=%b want 0 0 0 1 1", pixel_tick, xposition, video_on, hsync, vsync); end
   endtask

   // Three lines after enable: x=(k/2)%8, pixel every 2 CLK, line every 16 CLK.
   task automatic test_enable();
      int ex, ey;
      enable = 1'b1;
      k = -1;
      for (int i = 0; i < 48; i++) begin
         step();
         ex = (k / 2) % 8; ey = k / 16;
         checks++; if (pixel_tick !== (k % 2 == 1)) begin errors++; $display("FAIL en_tick k=%0d got %b", k, pixel_tick); end
         checks++; if (xposition !== 10'(ex)) begin errors++; $display("FAIL en_x k=%0d got %0d want %0d", k, xposition, ex); end
         checks++; if (yposition !== 10'(ey)) begin errors++; $display("FAIL en_y k=%0d got %0d want %0d", k, yposition, ey); end
         checks++; if (hsync !== !(ex == 5 || ex == 6)) begin errors++; $display("FAIL en_hsync k=%0d x=%0d got %b", k, ex, hsync); end
         checks++; if (video_on !== (ex < 4 && ey < 3)) begin errors++; $display("FAIL en_video_on k=%0d got %b", k, video_on); end
         checks++; if (line_end !== (k % 16 == 15)) begin errors++; $display("FAIL en_line_end k=%0d got %b", k, line_end); end
      end
   endtask

   task automatic test_frames();
      int ey;
      while (k < 191) begin
         step();
         ey = (k / 16) % 6;
         checks++; if (yposition !== 10'(ey)) begin errors++; $display("FAIL fr_y k=%0d got %0d want %0d", k, yposition, ey); end
         checks++; if (vsync !== (ey != 4)) begin errors++; $display("FAIL fr_vsync k=%0d y=%0d got %b", k, ey, vsync); end
         checks++; if (frame_end !== (k % 96 == 95)) begin errors++; $display("FAIL fr_frame_end k=%0d got %b", k, frame_end); end
         checks++; if (frame_end && !line_end) begin errors++; $display("FAIL fr_coincide k=%0d line_end=%b want 1", k, line_end); end
      end
   endtask

   // h_active raised mid-frame: current frame keeps H_total 8, next uses 10.
   task automatic test_shadow();
      int ex, ey, kk;
      while (k < 208) step();
      h_active = 10'd6;
      while (k < 287) begin
         step();
         ex = (k / 2) % 8; ey = (k / 16) % 6;
         checks++; if (xposition !== 10'(ex)) begin errors++; $display("FAIL sh_old_x k=%0d got %0d want %0d", k, xposition, ex); end
         checks++; if (video_on !== (ex < 4 && ey < 3)) begin errors++; $display("FAIL sh_old_von k=%0d got %b", k, video_on); end
         checks++; if (line_end !== (k % 16 == 15)) begin errors++; $display("FAIL sh_old_le k=%0d got %b", k, line_end); end
      end
      while (k < 333) begin
         step();
         kk = k - 288; ex = (kk / 2) % 10; ey = kk / 20;
         checks++; if (xposition !== 10'(ex)) begin errors++; $display("FAIL sh_new_x k=%0d got %0d want %0d", k, xposition, ex); end
         checks++; if (yposition !== 10'(ey)) begin errors++; $display("FAIL sh_new_y k=%0d got %0d want %0d", k, yposition, ey); end
         checks++; if (hsync !== !(ex == 7 || ex == 8)) begin errors++; $display("FAIL sh_new_hsync k=%0d got %b", k, hsync); end
         checks++; if (video_on !== (ex < 6 && ey < 3)) begin errors++; $display("FAIL sh_new_von k=%0d got %b", k, video_on); end
         checks++; if (line_end !== (kk % 20 == 19)) begin errors++; $display("FAIL sh_new_le k=%0d got %b", k, line_end); end
      end
   endtask

   task automatic test_disable();
      int ex;
      step();
      checks++; if (xposition !== 10'd3 || yposition !== 10'd2)
         begin errors++; $display("FAIL dis_pre got x=%0d y=%0d want x=3 y=2", xposition, yposition); end
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if ({xposition, yposition} !== 20'd0) begin errors++; $display("FAIL dis_xy got x=%0d y=%0d want 0 0", xposition, yposition); end
         checks++; if ({pixel_tick, line_end, frame_end, video_on, hsync, vsync} !== 6'b000011)
            begin errors++; $display("FAIL dis_flags got %b want 000011", {pixel_tick, line_end, frame_end, video_on, hsync, vsync}); end
      end
      enable = 1'b1;
      k = -1;
      for (int i = 0; i < 40; i++) begin
         step();
         ex = (k / 2) % 10;
         checks++; if (pixel_tick !== (k % 2 == 1)) begin errors++; $display("FAIL re_tick k=%0d got %b", k, pixel_tick); end
         checks++; if (xposition !== 10'(ex)) begin errors++; $display("FAIL re_x k=%0d got %0d want %0d", k, xposition, ex); end
         checks++; if (yposition !== 10'(k / 20)) begin errors++; $display("FAIL re_y k=%0d got %0d want %0d", k, yposition, k / 20); end
         checks++; if (line_end !== (k % 20 == 19)) begin errors++; $display("FAIL re_le k=%0d got %b", k, line_end); end
      end
   endtask

   task automatic test_timing_check();
      enable = 1'b0;
      h_sync = 10'd0;
      step(); step();
`ifdef VIDEO_TIMING_CHECK_EN
      checks++; if (timing_err !== 1'b1) begin errors++; $display("FAIL chk_err_set got %b want 1", timing_err); end
      enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++; if ({xposition, pixel_tick, line_end, video_on, hsync, vsync, timing_err} !== {10'd0, 6'b000111})
            begin errors++; $display("FAIL chk_hold x=%0d tick=%b le=%b von=%b hs=%b vs=%b err=%b want 0 0 0 0 1 1 1",
               xposition, pixel_tick, line_end, video_on, hsync, vsync, timing_err); end
      end
      enable = 1'b0;
`else
      checks++; if (timing_err !== 1'b0) begin errors++; $display("FAIL chk_err_tied got %b want 0", timing_err); end
`endif
      h_sync = 10'd2;
      step(); step();
      checks++; if (timing_err !== 1'b0) begin errors++; $display("FAIL chk_err_clear got %b want 0", timing_err); end
      enable = 1'b1;
      step(); step();
      checks++; if (pixel_tick !== 1'b1) begin errors++; $display("FAIL chk_resume_tick got %b want 1", pixel_tick); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 18; i++) step();
      checks++; if (xposition !== 10'd9) begin errors++; $display("FAIL ar_pre_x got %0d want 9", xposition); end
      #2 RESET = 1'b0;
      #1;
      checks++; if ({xposition, yposition} !== 20'd0) begin errors++; $display("FAIL ar_xy got x=%0d y=%0d want 0 0", xposition, yposition); end
      checks++; if ({pixel_tick, video_on, hsync, vsync} !== 4'b0011)
         begin errors++; $display("FAIL ar_flags got %b want 0011", {pixel_tick, video_on, hsync, vsync}); end
      enable = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
   endtask

   initial begin
      test_reset();
      test_enable();
      test_frames();
      test_shadow();
      test_disable();
      test_timing_check();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
